// File: rtl/dnpcie_aurora_pkg.sv
// rtl/dnpcie_aurora_pkg.sv - shared types and stored-word layout for the Aurora rx frame buffer
package dnpcie_aurora_pkg;

    typedef enum logic [1:0] {
        WR_IDLE     = 2'd0,
        WR_IN_FRAME = 2'd1,
        WR_DROP     = 2'd2
    } wr_state_t;

    // Stored word: {tdata[0:31], tkeep[0:3], tlast}
    localparam int WORD_BITS = 37;
    localparam int DATA_BITS = 32;
    localparam int KEEP_BITS = 4;
    localparam int DATA_LSB  = 5;
    localparam int KEEP_LSB  = 1;
    localparam int LAST_BIT  = 0;

    function automatic logic [WORD_BITS-1:0] pack_word(input logic [0:31] data,
                                                       input logic [0:3]  keep,
                                                       input logic        last);
        return {data, keep, last};
    endfunction

endpackage

// File: rtl/dnpcie_aurora_rx_frame_ram.sv
// rtl/dnpcie_aurora_rx_frame_ram.sv - simple dual-port RAM with registered, resettable read port
module dnpcie_aurora_rx_frame_ram #(
    parameter int ADDR_BITS = 9,
    parameter int WIDTH     = 37
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 we,
    input  logic [ADDR_BITS-1:0] waddr,
    input  logic [WIDTH-1:0]     wdata,
    input  logic                 re,
    input  logic [ADDR_BITS-1:0] raddr,
    output logic [WIDTH-1:0]     rdata
);

    logic [WIDTH-1:0] mem [0:(1<<ADDR_BITS)-1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // The read register doubles as the stream output register, hence the reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/dnpcie_aurora_rx_frame_buffer.sv
// rtl/dnpcie_aurora_rx_frame_buffer.sv - store-and-forward frame buffer behind the Aurora rx CRC checker
module dnpcie_aurora_rx_frame_buffer
    import dnpcie_aurora_pkg::*;
#(
    parameter int ADDR_BITS = 9,
    parameter int CNT_BITS  = 16
) (
    input  logic                 aclk,
    input  logic                 aresetn,
    input  logic                 channel_up,
    input  logic [0:31]          s_axis_tdata,
    input  logic [0:3]           s_axis_tkeep,
    input  logic                 s_axis_tvalid,
    input  logic                 s_axis_tuser,
    input  logic                 s_axis_tlast,
    input  logic                 s_axis_crc_pass_fail_n,
    input  logic                 s_axis_crc_valid,
    input  logic                 s_axis_length_err,
    output logic [0:31]          m_axis_tdata,
    output logic [0:3]           m_axis_tkeep,
    output logic                 m_axis_tvalid,
    output logic                 m_axis_tlast,
    input  logic                 m_axis_tready,
    output logic [CNT_BITS-1:0]  frames_ok,
    output logic [CNT_BITS-1:0]  frames_dropped,
    output logic                 overflow,
    output logic [ADDR_BITS:0]   words_used
);

    localparam logic [ADDR_BITS:0] PTR_ONE   = {{ADDR_BITS{1'b0}}, 1'b1};
    localparam logic [ADDR_BITS:0] DEPTH_PTR = {1'b1, {ADDR_BITS{1'b0}}};

    wr_state_t            state, state_nxt;
    logic [ADDR_BITS:0]   wr_ptr, commit_ptr, rd_ptr;
    logic [ADDR_BITS:0]   wr_ptr_nxt, commit_ptr_nxt, rd_ptr_nxt;
    logic [ADDR_BITS:0]   fill;
    logic                 full, frame_good, load, we;
    logic                 err_seen, err_seen_nxt;
    logic                 ok_inc, drop_inc, ovf_set;
    logic [WORD_BITS-1:0] rd_word;

    assign fill       = wr_ptr - rd_ptr;
    assign full       = (fill == DEPTH_PTR);
    assign frame_good = s_axis_crc_valid & s_axis_crc_pass_fail_n & ~s_axis_length_err
                      & ~err_seen & ~s_axis_tuser;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state <= WR_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (!channel_up) begin
            state_nxt = WR_IDLE;
        end else begin
            case (state)
                WR_IDLE: begin
                    if (s_axis_tvalid && !s_axis_tlast) begin
                        state_nxt = full ? WR_DROP : WR_IN_FRAME;
                    end
                end
                WR_IN_FRAME: begin
                    if (s_axis_tvalid) begin
                        if (s_axis_tlast) begin
                            state_nxt = WR_IDLE;
                        end else if (full) begin
                            state_nxt = WR_DROP;
                        end
                    end
                end
                WR_DROP: begin
                    if (s_axis_tvalid && s_axis_tlast) begin
                        state_nxt = WR_IDLE;
                    end
                end
                default: state_nxt = WR_IDLE;
            endcase
        end
    end

    always_comb begin
        we             = 1'b0;
        wr_ptr_nxt     = wr_ptr;
        commit_ptr_nxt = commit_ptr;
        ok_inc         = 1'b0;
        drop_inc       = 1'b0;
        ovf_set        = 1'b0;
        err_seen_nxt   = err_seen;
        if (!channel_up) begin
            // Link loss abandons any partial frame; committed data is untouched.
            wr_ptr_nxt   = commit_ptr;
            err_seen_nxt = 1'b0;
            drop_inc     = (state != WR_IDLE);
            ovf_set      = (state == WR_DROP);
        end else if (s_axis_tvalid) begin
            if (state == WR_DROP || full) begin
                if (s_axis_tlast) begin
                    wr_ptr_nxt   = commit_ptr;
                    drop_inc     = 1'b1;
                    ovf_set      = 1'b1;
                    err_seen_nxt = 1'b0;
                end
            end else begin
                we         = 1'b1;
                wr_ptr_nxt = wr_ptr + PTR_ONE;
                if (s_axis_tlast) begin
                    err_seen_nxt = 1'b0;
                    if (frame_good) begin
                        commit_ptr_nxt = wr_ptr + PTR_ONE;
                        ok_inc         = 1'b1;
                    end else begin
                        wr_ptr_nxt = commit_ptr;
                        drop_inc   = 1'b1;
                    end
                end else begin
                    err_seen_nxt = err_seen | s_axis_tuser;
                end
            end
        end
    end

    assign load       = (~m_axis_tvalid | m_axis_tready) & (rd_ptr != commit_ptr);
    assign rd_ptr_nxt = load ? rd_ptr + PTR_ONE : rd_ptr;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr         <= '0;
            commit_ptr     <= '0;
            rd_ptr         <= '0;
            err_seen       <= 1'b0;
            frames_ok      <= '0;
            frames_dropped <= '0;
            overflow       <= 1'b0;
            words_used     <= '0;
            m_axis_tvalid  <= 1'b0;
        end else begin
            wr_ptr     <= wr_ptr_nxt;
            commit_ptr <= commit_ptr_nxt;
            rd_ptr     <= rd_ptr_nxt;
            err_seen   <= err_seen_nxt;
            if (ok_inc) begin
                frames_ok <= frames_ok + CNT_BITS'(1);
            end
            if (drop_inc) begin
                frames_dropped <= frames_dropped + CNT_BITS'(1);
            end
            if (ovf_set) begin
                overflow <= 1'b1;
            end
            words_used <= commit_ptr_nxt - rd_ptr_nxt;
            if (load) begin
                m_axis_tvalid <= 1'b1;
            end else if (m_axis_tready) begin
                m_axis_tvalid <= 1'b0;
            end
        end
    end

    dnpcie_aurora_rx_frame_ram #(
        .ADDR_BITS (ADDR_BITS),
        .WIDTH     (WORD_BITS)
    ) u_ram (
        .clk   (aclk),
        .rst_n (aresetn),
        .we    (we),
        .waddr (wr_ptr[ADDR_BITS-1:0]),
        .wdata (pack_word(s_axis_tdata, s_axis_tkeep, s_axis_tlast)),
        .re    (load),
        .raddr (rd_ptr[ADDR_BITS-1:0]),
        .rdata (rd_word)
    );

    assign m_axis_tdata = rd_word[DATA_LSB +: DATA_BITS];
    assign m_axis_tkeep = rd_word[KEEP_LSB +: KEEP_BITS];
    assign m_axis_tlast = rd_word[LAST_BIT];

endmodule

// File: tb/tb_dnpcie_aurora_rx_frame_buffer.sv
// tb/tb_dnpcie_aurora_rx_frame_buffer.sv - directed self-checking bench for the rx frame buffer
module tb_dnpcie_aurora_rx_frame_buffer;

    localparam int AB = 4;
    localparam int CB = 16;

    logic          aclk = 1'b0;
    logic          aresetn = 1'b0;
    logic          channel_up = 1'b0;
    logic [0:31]   s_axis_tdata = '0;
    logic [0:3]    s_axis_tkeep = '0;
    logic          s_axis_tvalid = 1'b0;
    logic          s_axis_tuser = 1'b0;
    logic          s_axis_tlast = 1'b0;
    logic          s_axis_crc_pass_fail_n = 1'b0;
    logic          s_axis_crc_valid = 1'b0;
    logic          s_axis_length_err = 1'b0;
    logic [0:31]   m_axis_tdata;
    logic [0:3]    m_axis_tkeep;
    logic          m_axis_tvalid;
    logic          m_axis_tlast;
    logic          m_axis_tready = 1'b0;
    logic [CB-1:0] frames_ok;
    logic [CB-1:0] frames_dropped;
    logic          overflow;
    logic [AB:0]   words_used;

    int checks = 0;
    int errors = 0;
    logic [36:0] got_q[$];
    logic [36:0] exp_q[$];

    always #5 aclk = ~aclk;

    dnpcie_aurora_rx_frame_buffer #(.ADDR_BITS(AB), .CNT_BITS(CB)) dut (
        .aclk                   (aclk),
        .aresetn                (aresetn),
        .channel_up             (channel_up),
        .s_axis_tdata           (s_axis_tdata),
        .s_axis_tkeep           (s_axis_tkeep),
        .s_axis_tvalid          (s_axis_tvalid),
        .s_axis_tuser           (s_axis_tuser),
        .s_axis_tlast           (s_axis_tlast),
        .s_axis_crc_pass_fail_n (s_axis_crc_pass_fail_n),
        .s_axis_crc_valid       (s_axis_crc_valid),
        .s_axis_length_err      (s_axis_length_err),
        .m_axis_tdata           (m_axis_tdata),
        .m_axis_tkeep           (m_axis_tkeep),
        .m_axis_tvalid          (m_axis_tvalid),
        .m_axis_tlast           (m_axis_tlast),
        .m_axis_tready          (m_axis_tready),
        .frames_ok              (frames_ok),
        .frames_dropped         (frames_dropped),
        .overflow               (overflow),
        .words_used             (words_used)
    );

    always @(posedge aclk) begin
        if (aresetn && m_axis_tvalid && m_axis_tready) begin
            got_q.push_back({m_axis_tdata, m_axis_tkeep, m_axis_tlast});
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge aclk);
        #1;
    endtask

    task automatic do_reset();
        aresetn       = 1'b0;
        channel_up    = 1'b1;
        m_axis_tready = 1'b0;
        s_axis_tvalid = 1'b0;
        cycles(2);
        aresetn = 1'b1;
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic send_beat(input logic [31:0] data, input logic [3:0] keep, input logic last,
                             input logic user, input logic pass, input logic cvalid);
        s_axis_tdata           = data;
        s_axis_tkeep           = keep;
        s_axis_tlast           = last;
        s_axis_tuser           = user;
        s_axis_tvalid          = 1'b1;
        s_axis_crc_pass_fail_n = last & pass;
        s_axis_crc_valid       = last & cvalid;
        @(posedge aclk);
        #1;
        s_axis_tvalid    = 1'b0;
        s_axis_tlast     = 1'b0;
        s_axis_tuser     = 1'b0;
        s_axis_crc_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [31:0] base, input int n, input logic [3:0] keep_last,
                              input logic pass, input logic cvalid, input int user_idx,
                              input bit commit);
        for (int i = 0; i < n; i++) begin
            logic        last;
            logic [3:0]  keep;
            logic [31:0] data;
            last = (i == n - 1);
            keep = last ? keep_last : 4'hF;
            data = base + 32'(i);
            send_beat(data, keep, last, (i == user_idx), pass, cvalid);
            if (commit) begin
                exp_q.push_back({data, keep, last});
            end
        end
    endtask

    task automatic compare_out(input string tag);
        check({tag, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < got_q.size()) begin
                check($sformatf("%s_beat%0d", tag, i), 64'(got_q[i]), 64'(exp_q[i]));
            end
        end
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        // Reset values
        do_reset();
        check("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
        check("rst_tlast", 64'(m_axis_tlast), 64'd0);
        check("rst_tdata", 64'(m_axis_tdata), 64'd0);
        check("rst_tkeep", 64'(m_axis_tkeep), 64'd0);
        check("rst_ok", 64'(frames_ok), 64'd0);
        check("rst_drop", 64'(frames_dropped), 64'd0);
        check("rst_ovf", 64'(overflow), 64'd0);
        check("rst_used", 64'(words_used), 64'd0);

        // Two good 4-beat frames, continuous tready
        m_axis_tready = 1'b1;
        send_frame(32'hA000_0000, 4, 4'hF, 1'b1, 1'b1, -1, 1'b1);
        check("lat_idle", 64'(m_axis_tvalid), 64'd0);
        cycles(1);
        check("lat_tvalid", 64'(m_axis_tvalid), 64'd1);
        check("lat_tdata", 64'(m_axis_tdata), 64'hA000_0000);
        send_frame(32'hB000_0000, 4, 4'hF, 1'b1, 1'b1, -1, 1'b1);
        cycles(10);
        compare_out("two_frames");
        check("two_ok", 64'(frames_ok), 64'd2);
        check("two_used", 64'(words_used), 64'd0);

        // Bad CRC, good frame, tuser error, missing crc_valid
        do_reset();
        m_axis_tready = 1'b1;
        send_frame(32'hC000_0000, 3, 4'hF, 1'b0, 1'b1, -1, 1'b0);
        send_frame(32'hD000_0000, 2, 4'h8, 1'b1, 1'b1, -1, 1'b1);
        send_frame(32'hE000_0000, 2, 4'hF, 1'b1, 1'b1, 0, 1'b0);
        send_frame(32'hF000_0000, 2, 4'hF, 1'b1, 1'b0, -1, 1'b0);
        cycles(10);
        compare_out("bad_good");
        check("bad_ok", 64'(frames_ok), 64'd1);
        check("bad_drop", 64'(frames_dropped), 64'd3);
        check("bad_used", 64'(words_used), 64'd0);
        check("bad_ovf", 64'(overflow), 64'd0);

        // Buffer full: 12-word frame fits, following 6-word frame overflows
        do_reset();
        send_frame(32'h1200_0000, 12, 4'hF, 1'b1, 1'b1, -1, 1'b1);
        check("full_used_commit", 64'(words_used), 64'd12);
        send_frame(32'h0600_0000, 6, 4'hF, 1'b1, 1'b1, -1, 1'b0);
        cycles(2);
        check("full_ok", 64'(frames_ok), 64'd1);
        check("full_drop", 64'(frames_dropped), 64'd1);
        check("full_ovf", 64'(overflow), 64'd1);
        check("full_used_held", 64'(words_used), 64'd11);
        check("full_tvalid", 64'(m_axis_tvalid), 64'd1);
        m_axis_tready = 1'b1;
        cycles(20);
        compare_out("full_drain");
        check("full_used_end", 64'(words_used), 64'd0);
        check("full_ovf_sticky", 64'(overflow), 64'd1);

        // Channel loss after 3 beats of a 5-beat frame
        do_reset();
        m_axis_tready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            send_beat(32'h5500_0000 + 32'(i), 4'hF, 1'b0, 1'b0, 1'b1, 1'b1);
        end
        channel_up = 1'b0;
        cycles(1);
        channel_up = 1'b1;
        check("chan_drop", 64'(frames_dropped), 64'd1);
        check("chan_ok0", 64'(frames_ok), 64'd0);
        check("chan_used0", 64'(words_used), 64'd0);
        send_frame(32'h6600_0000, 3, 4'hF, 1'b1, 1'b1, -1, 1'b1);
        cycles(10);
        compare_out("chan_after");
        check("chan_ok1", 64'(frames_ok), 64'd1);

        // Single-beat frame, tready 1,0,1,0
        do_reset();
        m_axis_tready = 1'b1;
        send_frame(32'h1234_5678, 1, 4'hC, 1'b1, 1'b1, -1, 1'b1);
        cycles(1);
        m_axis_tready = 1'b0;
        check("one_tvalid", 64'(m_axis_tvalid), 64'd1);
        check("one_word", 64'({m_axis_tdata, m_axis_tkeep, m_axis_tlast}), {27'd0, 32'h1234_5678, 4'hC, 1'b1});
        cycles(1);
        check("one_hold", 64'({m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast}),
              {26'd0, 1'b1, 32'h1234_5678, 4'hC, 1'b1});
        m_axis_tready = 1'b1;
        cycles(1);
        m_axis_tready = 1'b0;
        check("one_taken", 64'(m_axis_tvalid), 64'd0);
        cycles(3);
        compare_out("one_beat");

        // Asynchronous reset with data buffered and tvalid high
        do_reset();
        send_frame(32'h7700_0000, 3, 4'hF, 1'b1, 1'b1, -1, 1'b0);
        send_frame(32'h8800_0000, 2, 4'hF, 1'b0, 1'b1, -1, 1'b0);
        cycles(3);
        check("ar_pre_tvalid", 64'(m_axis_tvalid), 64'd1);
        check("ar_pre_used", 64'(words_used), 64'd2);
        #2;
        aresetn = 1'b0;
        #1;
        check("ar_tvalid", 64'(m_axis_tvalid), 64'd0);
        check("ar_tdata", 64'(m_axis_tdata), 64'd0);
        check("ar_tlast", 64'(m_axis_tlast), 64'd0);
        check("ar_ok", 64'(frames_ok), 64'd0);
        check("ar_drop", 64'(frames_dropped), 64'd0);
        check("ar_used", 64'(words_used), 64'd0);
        got_q.delete();
        exp_q.delete();
        cycles(2);
        aresetn       = 1'b1;
        m_axis_tready = 1'b1;
        cycles(10);
        compare_out("ar_stale");
        check("ar_post_tvalid", 64'(m_axis_tvalid), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dnpcie_aurora_rx_frame_buffer.md
Name: dnpcie_aurora_rx_frame_buffer

Overview:
- Store-and-forward frame buffer directly downstream of the Aurora receive CRC checker.
- The receive path has no backpressure, so this block absorbs the unbuffered 32-bit CRC-stripped stream into on-chip memory.
- It commits only frames that pass CRC and length checks and fit in the buffer; all other frames are discarded.
- It presents committed frames on a backpressured AXI4-Stream master for the merger logic.

Parameters:
- ADDR_BITS, 9, log2 of buffer depth in 37-bit words (data 32 + tkeep 4 + tlast 1).
- CNT_BITS, 16, width of the frame statistics counters.

Ports:
- aclk  in  1  user clock, shared with the Aurora core.
- aresetn  in  1  reset: asynchronous assert, active-low.
- channel_up  in  1  Aurora channel status.
- s_axis_tdata  in  [0:31]  received data, big-endian bit order.
- s_axis_tkeep  in  [0:3]  byte enables.
- s_axis_tvalid  in  1  beat valid. There is no tready; every valid beat must be taken.
- s_axis_tuser  in  1  beat error flag from the checker.
- s_axis_tlast  in  1  last beat of frame.
- s_axis_crc_pass_fail_n  in  1  CRC result; 1 = pass.
- s_axis_crc_valid  in  1  qualifies the CRC result.
- s_axis_length_err  in  1  length error from the checker.
- m_axis_tdata  out  [0:31]  frame data out.
- m_axis_tkeep  out  [0:3]  byte enables out.
- m_axis_tvalid  out  1  output beat valid.
- m_axis_tlast  out  1  output last beat.
- m_axis_tready  in  1  downstream ready.
- frames_ok  out  CNT_BITS  committed frame count, wrapping.
- frames_dropped  out  CNT_BITS  discarded frame count, wrapping.
- overflow  out  1  sticky: at least one frame dropped because the buffer was full. Cleared only by reset.
- words_used  out  ADDR_BITS+1  committed words not yet read.

Behaviour:
- Reset values:
  - m_axis_tvalid = 0, m_axis_tlast = 0; tdata and tkeep = 0.
  - Counters = 0, overflow = 0, words_used = 0.
  - All pointers = 0; write FSM = IDLE.
- Memory: simple dual-port, DEPTH = 2**ADDR_BITS.
- Pointers: wr_ptr, commit_ptr and rd_ptr are ADDR_BITS+1 bits wide.
  - full when wr_ptr - rd_ptr == DEPTH.
  - empty-for-read when rd_ptr == commit_ptr.
- Frame verdict:
  - The CRC result, crc_valid and length_err are qualified on the tvalid&tlast beat (same cycle).
  - good = crc_valid & pass_fail_n & ~length_err & ~tuser-seen-in-frame.
  - If crc_valid is low on the tlast beat, the frame is treated as bad.
- Write FSM:
  - IDLE: a tvalid beat with channel_up writes the beat and enters IN_FRAME. If that beat also has tlast, the frame is resolved immediately and the FSM stays in IDLE. If the buffer is full, go to DROP instead.
  - IN_FRAME: each beat writes mem[wr_ptr] and increments wr_ptr. A beat arriving while full sets drop and moves to DROP without writing.
  - On tlast in IN_FRAME:
    - good: commit_ptr <= wr_ptr+1 and frames_ok++.
    - bad: wr_ptr <= commit_ptr and frames_dropped++.
    - Either way, return to IDLE.
  - DROP: discard beats. On tlast: wr_ptr <= commit_ptr, frames_dropped++, overflow <= 1, return to IDLE.
  - channel_up low in any state: wr_ptr <= commit_ptr, FSM -> IDLE. An in-progress frame counts as dropped. Committed frames stay readable.
- Read side:
  - One-stage registered output fed from the memory read.
  - The output register loads when (~m_axis_tvalid | m_axis_tready) and rd_ptr != commit_ptr; rd_ptr increments on each load.
  - m_axis_tvalid holds with stable data until accepted.
  - Full throughput: one beat per cycle under continuous tready.
- Latency: first word of a committed frame appears on m_axis no later than 2 cycles after the tlast beat's clock edge.
- A commit and a read in the same cycle are independent. words_used = commit_ptr - rd_ptr, registered.
- Frames never straddle a discard: the reader never sees an uncommitted word.
- The maximum frame that can be stored is DEPTH words; longer frames are always dropped (overflow).

Decomposition:
- Shared package dnpcie_aurora_pkg: write-FSM state encoding (IDLE, IN_FRAME, DROP) and the 37-bit stored word layout constant.
- One sub-module, dnpcie_aurora_rx_frame_ram: inferred simple dual-port RAM with registered read.

Test Plan:
- Two 4-beat good frames, tready=1 -> 8 beats out in order with tlast on beats 4 and 8; frames_ok=2; first output beat 2 cycles after the first tlast.
- 3-beat frame with pass_fail_n=0 on tlast, followed by a good 2-beat frame -> only the 2-beat frame is output; frames_dropped=1, frames_ok=1, words_used returns to 0.
- ADDR_BITS=4, tready=0: a 12-word good frame then a 6-word frame -> first frame committed (words_used=12); second dropped; overflow=1; releasing tready outputs exactly 12 beats.
- channel_up deasserted mid-way through a 5-beat frame after 3 beats -> nothing output for that frame; frames_dropped=1; a subsequent good frame passes intact.
- Single-beat good frame (tvalid&tlast, tkeep=4'hC) with tready toggling 1010 -> one beat output with tlast=1 and tkeep=4'hC, held stable until accepted.
- aresetn asserted while m_axis_tvalid=1 and frame data is buffered -> all outputs, counters and words_used clear asynchronously; no stale beats after release.
